cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Run/halt/single-step controller for the nic8 CPU core. It sits between the front-panel/debug inputs and the datapath, and produces the per-cycle clock-enable that lets the instruction decoder and register triggers advance. It also detects breakpoints on the program counter and jump-to-self spin loops, and counts retired instructions.

## Interface
Parameters:
- `COUNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `run_req`  in  1  one-cycle pulse: start free running.
- `halt_req`  in  1  one-cycle pulse: stop before the next instruction.
- `step_req`  in  1  one-cycle pulse: execute exactly one instruction.
- `bp_enable`  in  1  breakpoint compare enabled.
- `bp_addr`  in  8  breakpoint PC value.
- `pc`  in  8  current program counter from the datapath.
- `jump_taken`  in  1  active-high, equal to the inverse of the decoder's jump strobe for the current instruction.
- `cpu_enable`  out  1  datapath advances one instruction on a cycle where this is high.
- `halted`  out  1  high in HALT state.
- `halt_cause`  out  2  0 NONE, 1 USER, 2 BREAK, 3 SPIN.
- `instr_count`  out  COUNT_W  retired instructions, saturating.

## Operation
- States: HALT, RUN, STEP. Reset state is HALT.
- Reset values: state HALT, `halt_cause` NONE, `instr_count` 0, `skip_bp` 0, `spin_armed` 0.
- Request priority in any state: `halt_req` > `step_req` > `run_req`. Requests arriving in a state where they have no effect are dropped; they are not queued.
- HALT:
  - `run_req` → RUN, with `skip_bp` set.
  - `step_req` → STEP, with `skip_bp` set.
  - `cpu_enable` is 0.
- RUN, evaluated each cycle in this order:
  - If `halt_req`: → HALT, cause USER, `cpu_enable` 0.
  - Else if `spin_armed` and `pc == last_pc`: → HALT, cause SPIN, `cpu_enable` 0.
  - Else if `bp_enable`, `pc == bp_addr` and not `skip_bp`: → HALT, cause BREAK, `cpu_enable` 0.
  - Else: `cpu_enable` 1 and `skip_bp` clears.
  - `step_req` and `run_req` are ignored in RUN.
- STEP:
  - `cpu_enable` is 1 for exactly one cycle, then → HALT with cause NONE.
  - Breakpoint and spin checks do not apply.
  - `halt_req` in the STEP cycle suppresses the instruction: `cpu_enable` 0, → HALT with cause USER.
- Spin detection:
  - On every cycle with `cpu_enable` = 1, `last_pc` ← `pc` and `spin_armed` ← `jump_taken`.
  - On every cycle with `cpu_enable` = 0, `spin_armed` ← 0.
- `instr_count` increments on each cycle with `cpu_enable` = 1. It holds at all-ones and never wraps.
- `halt_cause` updates only on entry to HALT. It holds its value while halted and is cleared to NONE on leaving HALT.

## Timing
- `cpu_enable` is combinational from the registered state and the current `pc`/`jump_taken`/`halt_req`. It is valid within the same cycle, and the datapath samples it on the same edge.
- Latency:
  - `run_req` at edge N: first `cpu_enable` in cycle N+1.
  - `step_req` at edge N: `cpu_enable` high in cycle N+1 only; `halted` high again from cycle N+2.
  - `halt_req` in RUN: `cpu_enable` low in the same cycle; `halted` high the next cycle.
- Breakpoint:
  - The instruction at `bp_addr` is not executed.
  - A following `run_req` or `step_req` executes it, because `skip_bp` exempts the first instruction only.
- Spin is detected one cycle after the self-jump retires. That jump is counted; no further instruction is executed.
- Simultaneous breakpoint and spin: SPIN wins.
- `reset` mid-RUN or mid-STEP: next cycle is HALT with all reset values. `cpu_enable` is 0 in the reset cycle.
- `pc` wraps 0xFF→0x00 naturally. Compares are 8-bit equality only.

## Structure
- Shared package `nic8_pkg`: state encoding (HALT = 0, RUN = 1, STEP = 2) and `halt_cause` constants (NONE/USER/BREAK/SPIN).
- One sub-module: `sat_counter` (parameter W; inputs `clk`, `reset`, `inc`; output `count`). It implements `instr_count`.
- The rest is a single FSM process plus registers `last_pc`, `spin_armed` and `skip_bp`.

## Test plan
- Reset then idle 10 cycles → `halted` 1, `cpu_enable` 0, `halt_cause` 0, `instr_count` 0.
- From HALT, pulse `step_req` three times, 4 cycles apart, with `pc` advancing 0x00→0x03 → exactly 3 single-cycle `cpu_enable` pulses, `instr_count` 3, `halt_cause` 0.
- `bp_enable` 1, `bp_addr` 0x05, `run_req`, `pc` incrementing from 0x00:
  - → `cpu_enable` for pc 0x00–0x04, halt with cause 2 at pc 0x05, `instr_count` 5.
  - A second `run_req` → pc 0x05 executes and running resumes.
- `run_req` with `pc` stuck at 0x10 and `jump_taken` 1 → one enable, then HALT with cause 3, `instr_count` 1.
- In RUN, assert `halt_req` and `step_req` in the same cycle → `cpu_enable` 0 that cycle, `halt_cause` 1, no STEP entered.
- Force `instr_count` to all-ones via long run (`COUNT_W` = 4, 20 instructions) → holds at 15. `reset` asserted mid-RUN → HALT with count 0 the next cycle.

Source files
------------

// File: rtl/nic8_pkg.sv
// Shared encodings for the nic8 run/halt/step sequencer: FSM states and halt causes.
package nic8_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_USER  = 2'd1,
        CAUSE_BREAK = 2'd2,
        CAUSE_SPIN  = 2'd3
    } halt_cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: advances on inc, sticks at all-ones, cleared by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Run/halt/single-step controller for the nic8 core: gates the datapath clock-enable,
// stops on PC breakpoints and jump-to-self spin loops, and counts retired instructions.
module cpu_sequencer
    import nic8_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               bp_enable,
    input  logic [7:0]         bp_addr,
    input  logic [7:0]         pc,
    input  logic               jump_taken,
    output logic               cpu_enable,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic [COUNT_W-1:0] instr_count
);

    seq_state_t  state;
    halt_cause_t cause;
    logic        skip_bp;
    logic        spin_armed;
    logic [7:0]  last_pc;

    logic        stop;
    halt_cause_t stop_cause;

    // Same-cycle decision: the datapath samples cpu_enable on the edge that ends this cycle.
    always_comb begin
        cpu_enable = 1'b0;
        stop       = 1'b0;
        stop_cause = CAUSE_NONE;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    stop       = 1'b1;
                    stop_cause = CAUSE_USER;
                end else if (spin_armed && (pc == last_pc)) begin
                    stop       = 1'b1;
                    stop_cause = CAUSE_SPIN;
                end else if (bp_enable && (pc == bp_addr) && !skip_bp) begin
                    stop       = 1'b1;
                    stop_cause = CAUSE_BREAK;
                end else begin
                    cpu_enable = 1'b1;
                end
            end
            ST_STEP: begin
                stop = 1'b1;
                if (halt_req) begin
                    stop_cause = CAUSE_USER;
                end else begin
                    cpu_enable = 1'b1;
                end
            end
            default: ;
        endcase
        if (reset) begin
            cpu_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_HALT;
            cause      <= CAUSE_NONE;
            skip_bp    <= 1'b0;
            spin_armed <= 1'b0;
        end else begin
            case (state)
                ST_HALT: begin
                    if (step_req) begin
                        state   <= ST_STEP;
                        cause   <= CAUSE_NONE;
                        skip_bp <= 1'b1;
                    end else if (run_req) begin
                        state   <= ST_RUN;
                        cause   <= CAUSE_NONE;
                        skip_bp <= 1'b1;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (stop) begin
                        state <= ST_HALT;
                        cause <= stop_cause;
                    end
                end
                default: state <= ST_HALT;
            endcase
            // The breakpoint exemption covers only the first instruction after leaving HALT.
            if (cpu_enable) begin
                spin_armed <= jump_taken;
                if (state == ST_RUN) begin
                    skip_bp <= 1'b0;
                end
            end else begin
                spin_armed <= 1'b0;
            end
        end
    end

    // last_pc is only meaningful while spin_armed is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cpu_enable) begin
            last_pc <= pc;
        end
    end

    sat_counter #(.W(COUNT_W)) u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_enable),
        .count (instr_count)
    );

    assign halted     = (state == ST_HALT);
    assign halt_cause = cause;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the run/halt/step rules.
module tb_cpu_sequencer;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          run_req;
    logic          halt_req;
    logic          step_req;
    logic          bp_enable;
    logic [7:0]    bp_addr;
    logic [7:0]    pc;
    logic          jump_taken;
    logic          cpu_enable;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [CW-1:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.COUNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .bp_enable   (bp_enable),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .jump_taken  (jump_taken),
        .cpu_enable  (cpu_enable),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .instr_count (instr_count)
    );

    // Behavioural model of the sequencer
    bit         m_running, m_stepping, m_skip, m_armed;
    int         m_cause, m_count;
    logic [7:0] m_last;

    bit         pc_auto;
    logic [7:0] jump_target;
    int         en_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_running  = 0;
        m_stepping = 0;
        m_skip     = 0;
        m_armed    = 0;
        m_cause    = 0;
        m_count    = 0;
        m_last     = 8'h00;
    endtask

    task automatic model_stop(input int c);
        m_running  = 0;
        m_stepping = 0;
        m_cause    = c;
    endtask

    // One clock cycle: check outputs mid-cycle, advance model, then step the datapath pc.
    task automatic tick();
        bit en;
        bit spin_hit, bp_hit;
        @(negedge clk);
        spin_hit = m_armed && (pc == m_last);
        bp_hit   = bp_enable && (pc == bp_addr) && !m_skip;
        en = 0;
        if (!reset) begin
            if (m_running)       en = !halt_req && !spin_hit && !bp_hit;
            else if (m_stepping) en = !halt_req;
        end
        chk("cpu_enable",  32'(cpu_enable),  32'(en));
        chk("halted",      32'(halted),      32'(!(m_running || m_stepping)));
        chk("halt_cause",  32'(halt_cause),  32'(m_cause));
        chk("instr_count", 32'(instr_count), 32'(m_count));
        if (en) en_seen++;
        if (reset) begin
            model_reset();
        end else begin
            if (m_running) begin
                if (halt_req)      model_stop(1);
                else if (spin_hit) model_stop(3);
                else if (bp_hit)   model_stop(2);
                else               m_skip = 0;
            end else if (m_stepping) begin
                model_stop(halt_req ? 1 : 0);
            end else if (step_req) begin
                m_stepping = 1; m_skip = 1; m_cause = 0;
            end else if (run_req) begin
                m_running = 1; m_skip = 1; m_cause = 0;
            end
            if (en) begin
                m_count = (m_count >= CMAX) ? CMAX : m_count + 1;
                m_last  = pc;
                m_armed = jump_taken;
            end else begin
                m_armed = 0;
            end
        end
        @(posedge clk);
        #1;
        run_req  = 0;
        halt_req = 0;
        step_req = 0;
        if (pc_auto && en) pc = jump_taken ? jump_target : pc + 8'd1;
    endtask

    task automatic pulse_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1; run_req = 0; halt_req = 0; step_req = 0;
        bp_enable = 0; bp_addr = 8'h00; pc = 8'h00; jump_taken = 0;
        jump_target = 8'h00; pc_auto = 1; en_seen = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset then idle
        tick();
        reset = 0;
        repeat (10) tick();
        chk("idle_halted", 32'(halted), 32'd1);
        chk("idle_count",  32'(instr_count), 32'd0);

        // Three single steps, 4 cycles apart
        en_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step_req = 1;
            repeat (4) tick();
        end
        chk("step_pulses", 32'(en_seen), 32'd3);
        chk("step_pc",     32'(pc), 32'h03);
        chk("step_count",  32'(instr_count), 32'd3);
        chk("step_cause",  32'(halt_cause), 32'd0);

        // Breakpoint at 0x05, then resume past it
        pulse_reset();
        pc = 8'h00; bp_enable = 1; bp_addr = 8'h05;
        run_req = 1;
        repeat (9) tick();
        chk("bp_cause", 32'(halt_cause), 32'd2);
        chk("bp_count", 32'(instr_count), 32'd5);
        chk("bp_pc",    32'(pc), 32'h05);
        en_seen = 0;
        run_req = 1;
        repeat (4) tick();
        chk("bp_resume", 32'(en_seen), 32'd3);
        chk("bp_run",    32'(halted), 32'd0);

        // Spin loop at 0x10
        pulse_reset();
        bp_enable = 0; pc = 8'h10; jump_taken = 1; pc_auto = 0;
        run_req = 1;
        repeat (4) tick();
        chk("spin_cause", 32'(halt_cause), 32'd3);
        chk("spin_count", 32'(instr_count), 32'd1);

        // halt_req and step_req together in RUN
        pulse_reset();
        pc = 8'h20; jump_taken = 0; pc_auto = 1;
        run_req = 1;
        repeat (3) tick();
        halt_req = 1; step_req = 1;
        tick();
        chk("hs_cause", 32'(halt_cause), 32'd1);
        repeat (2) tick();
        chk("hs_halted", 32'(halted), 32'd1);

        // Saturation, then reset mid-run
        pulse_reset();
        pc = 8'h00;
        run_req = 1;
        repeat (22) tick();
        chk("sat_count", 32'(instr_count), 32'(CMAX));
        pulse_reset();
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_count",  32'(instr_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            run_req  = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 23) == 0);
            step_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) bp_enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) bp_addr = 8'($urandom_range(0, 15));
            jump_taken  = ($urandom_range(0, 3) == 0);
            jump_target = ($urandom_range(0, 1) == 1) ? pc : 8'($urandom_range(0, 15));
            tick();
        end
        reset = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
